br_write_arbiter: RTL

//  Shares the single write port of the 32x32 register bank (BR) between two

---
 rtl/br_pkg.sv | 23 ++
 rtl/br_req_fifo.sv | 77 +++++++
 rtl/br_write_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/br_pkg.sv
`default_nettype none
// ============================================================================
// Module  : br_pkg
// Brief   : Shared widths and the write-request record used by the register
//           bank write arbiter and its per-requester FIFOs.
// Revision: 1.0 - initial release
// ============================================================================
package br_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // Register $zero: writes to it are consumed without reaching the bank.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] adrs;
        logic [DATA_W-1:0] data;
    } br_wr_t;

endpackage
`default_nettype wire

// File: rtl/br_req_fifo.sv
`default_nettype none
// ============================================================================
// Module  : br_req_fifo
// Brief   : Small synchronous FIFO of write requests. Every slot carries its
//           own valid bit, so the pending-register vector can be built
//           straight from the storage without decoding pointers.
// Revision: 1.0 - initial release
// ============================================================================
module br_req_fifo
    import br_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_push,
    input  br_wr_t                           i_data,
    input  logic                             i_pop,
    output logic                             o_full,
    output logic                             o_empty,
    output br_wr_t                           o_head,
    output logic [DEPTH-1:0]                 o_entry_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0]     o_entry_adrs
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

    br_wr_t             r_mem [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;

    // Ring pointer advance that also works for non-power-of-two depths.
    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    // Control state: slot valids and ring pointers. The caller never pushes
    // while full nor pops while empty, so push and pop never hit the same slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= f_next(r_rd_ptr);
            end
            if (i_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
        end
    end

    // Payload storage needs no reset; slot valids qualify every read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_full      = &r_vld;
    assign o_empty     = ~|r_vld;
    assign o_head      = r_mem[r_rd_ptr];
    assign o_entry_vld = r_vld;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign o_entry_adrs[gi] = r_mem[gi].adrs;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/br_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : br_write_arbiter
// Brief   : Shares the register bank write port between the ALU result (A)
//           and memory load (B) writeback paths. Each path is buffered in a
//           small FIFO; heads are granted round-robin into registered bank
//           write outputs. A pending vector flags registers with a write
//           still queued or on the port.
// Revision: 1.0 - initial release
// ============================================================================
module br_write_arbiter
    import br_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_adrs,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_W-1:0]   b_adrs,
    input  logic [DATA_W-1:0]   b_data,
    output logic                RegEn,
    output logic [ADDR_W-1:0]   adrsWrite,
    output logic [DATA_W-1:0]   write,
    output logic [NUM_REGS-1:0] pending
);

    logic                         w_a_full, w_a_empty, w_b_full, w_b_empty;
    logic                         w_a_push, w_b_push, w_pop_a, w_pop_b;
    br_wr_t                       w_a_wr, w_b_wr, w_a_head, w_b_head, w_head;
    logic [DEPTH-1:0]             w_a_vld, w_b_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] w_a_adrs, w_b_adrs;
    logic [NUM_REGS-1:0]          w_pending;

    logic                         r_regen;
    logic [ADDR_W-1:0]            r_adrs;
    logic [DATA_W-1:0]            r_data;
    logic                         r_tie_a;   // 1: A wins the next tie

    // Ready depends only on occupancy before any same-cycle pop, so a full
    // FIFO refuses a push even in the cycle its head leaves.
    assign a_ready  = ~w_a_full;
    assign b_ready  = ~w_b_full;
    assign w_a_push = a_valid & ~w_a_full;
    assign w_b_push = b_valid & ~w_b_full;
    assign w_a_wr   = '{adrs: a_adrs, data: a_data};
    assign w_b_wr   = '{adrs: b_adrs, data: b_data};

    // Round-robin grant: a lone non-empty FIFO always wins.
    assign w_pop_a = ~w_a_empty & (w_b_empty | r_tie_a);
    assign w_pop_b = ~w_b_empty & (w_a_empty | ~r_tie_a);
    assign w_head  = w_pop_a ? w_a_head : w_b_head;

    br_req_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_a_push),
        .i_data       (w_a_wr),
        .i_pop        (w_pop_a),
        .o_full       (w_a_full),
        .o_empty      (w_a_empty),
        .o_head       (w_a_head),
        .o_entry_vld  (w_a_vld),
        .o_entry_adrs (w_a_adrs)
    );

    br_req_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_b_push),
        .i_data       (w_b_wr),
        .i_pop        (w_pop_b),
        .o_full       (w_b_full),
        .o_empty      (w_b_empty),
        .o_head       (w_b_head),
        .o_entry_vld  (w_b_vld),
        .o_entry_adrs (w_b_adrs)
    );

    // Output register: load the granted head; $zero writes are swallowed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regen <= 1'b0;
            r_adrs  <= '0;
            r_data  <= '0;
            r_tie_a <= 1'b1;
        end else if (w_pop_a | w_pop_b) begin
            r_regen <= (w_head.adrs != REG_ZERO);
            r_adrs  <= w_head.adrs;
            r_data  <= w_head.data;
            r_tie_a <= w_pop_b;
        end else begin
            r_regen <= 1'b0;
        end
    end

    // Pending vector: every queued destination plus the one on the port.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_a_vld[i]) w_pending[w_a_adrs[i]] = 1'b1;
            if (w_b_vld[i]) w_pending[w_b_adrs[i]] = 1'b1;
        end
        if (r_regen) w_pending[r_adrs] = 1'b1;
        w_pending[0] = 1'b0;
    end

    assign RegEn     = r_regen;
    assign adrsWrite = r_adrs;
    assign write     = r_data;
    assign pending   = w_pending;

endmodule
`default_nettype wire
